// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, controller
// state type and the op-class helper used when capturing overflow.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } ctrl_state_t;

    // Only arithmetic ops produce a meaningful overflow flag.
    function automatic logic op_has_ovf(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB:                                 r = 1'b1;
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_EQ:   r = 1'b0;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO: DEPTH entries of WIDTH bits with occupancy count,
// full/empty flags and a head output that reads as zero when empty.
module alu_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 71
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage, pointers (wrap modulo DEPTH) and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Requester-side controller for the combinational ALU: queues requests,
// drives the ALU from the queue head, registers results into a
// valid/ready response slot, and tracks sticky overflow and op count.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [31:0]       alu_r1,
    output logic [31:0]       alu_r2,
    output logic [2:0]        alu_sub,
    input  logic [31:0]       alu_sum,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_ovf,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              ovf_sticky,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  ops_done
);

    localparam int unsigned ENT_W = 3 + 32 + 32 + TAG_W;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic [2:0]        head_op;
    logic [31:0]       head_a;
    logic [31:0]       head_b;
    logic [TAG_W-1:0]  head_tag;
    logic              cap_ovf;
    logic              valid_next;
    logic [CW-1:0]     cnt_next;
    ctrl_state_t       state_q;
    ctrl_state_t       state_d;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({req_op, req_a, req_b, req_tag}),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_op, head_a, head_b, head_tag} = fifo_head;

    // Head reads as zero when the FIFO is empty, so the ALU idles at 0.
    assign alu_r1  = head_a;
    assign alu_r2  = head_b;
    assign alu_sub = head_op;

    assign cap_ovf = alu_overflow && op_has_ovf(head_op);

    // Capture decision, next slot/occupancy and next controller state.
    // State is derived from the post-edge occupancy and slot, so STALL
    // always implies a non-empty FIFO with a full slot and IDLE an empty one.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            RUN:     pop = !fifo_empty && (!rsp_valid || rsp_ready);
            STALL:   pop = rsp_ready;
            default: pop = 1'b0;
        endcase

        valid_next = rsp_valid;
        if (pop) begin
            valid_next = 1'b1;
        end else if (rsp_ready) begin
            valid_next = 1'b0;
        end

        cnt_next = fifo_count;
        if (push && !pop) begin
            cnt_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            cnt_next = fifo_count - 1'b1;
        end

        if (cnt_next == '0 && !valid_next) begin
            state_d = IDLE;
        end else if (valid_next && cnt_next != '0) begin
            state_d = STALL;
        end else begin
            state_d = RUN;
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response slot: load from the ALU on capture, hold while blocked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            rsp_valid <= valid_next;
            if (pop) begin
                rsp_data <= alu_sum;
                rsp_ovf  <= cap_ovf;
                rsp_tag  <= head_tag;
            end
        end
    end

    // Sticky overflow: a capturing overflow beats a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (pop && cap_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (rsp_valid && rsp_ready) begin
            ops_done <= ops_done + 1'b1;
        end
    end

endmodule
